// File: rtl/serial_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit adder slice with carry-out and the carry into its top bit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign sum      = full_sum[DIGIT-1:0];
  assign cout     = full_sum[DIGIT];
  // Carry into the top bit recovered from that bit's sum and operands.
  assign c_msb    = full_sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, one result per N+1 cycles.
module serial_add_sub
  import serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % DIGIT) != 0 || N < 2) begin : g_param_check
    $error("serial_add_sub: DIGIT must divide WIDTH with at least two steps");
  end

  state_t            state_reg, state_next;
  logic              accept;
  logic [WIDTH-1:0]  a_reg, b_reg, res_reg, out_reg;
  logic              carry_reg, cout_reg, ovf_reg;
  logic [CW-1:0]     count_reg;
  logic [DIGIT-1:0]  dig_sum;
  logic              dig_cout, dig_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a     (a_reg[DIGIT-1:0]),
    .b     (b_reg[DIGIT-1:0]),
    .cin   (carry_reg),
    .sum   (dig_sum),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        if (count_reg == LAST) state_next = DONE;
      end
      DONE: begin
        // A start in the done cycle chains straight into the next operation.
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      out_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        // Subtraction as A + ~B + 1: the +1 enters through the initial carry.
        a_reg     <= data_a;
        b_reg     <= (sub == MODE_SUB) ? ~data_b : data_b;
        carry_reg <= (sub == MODE_SUB);
        count_reg <= '0;
        res_reg   <= '0;
      end else if (state_reg == RUN) begin
        a_reg     <= a_reg >> DIGIT;
        b_reg     <= b_reg >> DIGIT;
        carry_reg <= dig_cout;
        count_reg <= count_reg + CW'(1);
        res_reg   <= {dig_sum, res_reg[WIDTH-1:DIGIT]};
        if (count_reg == LAST) begin
          out_reg  <= {dig_sum, res_reg[WIDTH-1:DIGIT]};
          cout_reg <= dig_cout;
          ovf_reg  <= dig_cmsb ^ dig_cout;
        end
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign out  = out_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
